// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA framebuffer fetch path.
package vga_pkg;

    localparam int          DEF_H_ACTIVE   = 640;
    localparam int          DEF_V_ACTIVE   = 480;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_0000;
    localparam int          DEF_FIFO_DEPTH = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head data is presented combinationally.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer scan engine: linear word reads over req/ack into a prefetch FIFO.
// Define VGA_FETCH_STATS_EN to add the saturating underflow_cnt output.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE   = DEF_H_ACTIVE,
    parameter int          V_ACTIVE   = DEF_V_ACTIVE,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         pix_rd,
    output logic [23:0]  pix_data,
    output logic         underflow,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
`ifdef VGA_FETCH_STATS_EN
    output logic [15:0]  underflow_cnt,
`endif
    output fetch_state_t fsm_state
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((H_ACTIVE * V_ACTIVE - 1) * 4);

    // Memory handshake: mem_req/mem_addr stay constant from request until the
    // cycle mem_ack is high; that cycle completes the transfer and carries data.
    fetch_state_t state, state_nxt;
    logic [31:0]  ptr;
    logic [31:0]  addr_q;
    rgb_t         pix_q;
    rgb_t         head;
    logic [AW:0]  count;
    logic         empty;
    logic         full;
    logic         accept;
    logic         rd_ok;
    logic         uf_hit;
    logic         pop;

    wire unused_ok = &{1'b0, mem_rdata[31:24], count};

    always_comb begin
        rd_ok  = pix_rd && !frame_start;
        accept = mem_ack && (state == REQ) && !frame_start;
        pop    = rd_ok && !empty;
        uf_hit = rd_ok && empty;
    end

    sync_fifo #(
        .WIDTH ($bits(rgb_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .flush (frame_start),
        .wdata (mem_rdata[23:0]),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // An ack coinciding with frame_start completes the transfer; its data is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!frame_start && !full) state_nxt = REQ;
            REQ: begin
                if (mem_ack)          state_nxt = IDLE;
                else if (frame_start) state_nxt = DRAIN;
            end
            DRAIN:   if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= BASE_ADDR;
            addr_q    <= BASE_ADDR;
            pix_q     <= '0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            underflow <= uf_hit;
            if (state == IDLE && state_nxt == REQ) addr_q <= ptr;
            if (frame_start)  ptr <= BASE_ADDR;
            else if (accept)  ptr <= (ptr == LAST_ADDR) ? BASE_ADDR : ptr + 32'd4;
            if (rd_ok)        pix_q <= empty ? '0 : head;
        end
    end

`ifdef VGA_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                                   underflow_cnt <= '0;
        else if (uf_hit && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

    assign mem_req   = (state != IDLE);
    assign mem_addr  = addr_q;
    assign pix_data  = pix_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized scoreboard bench for vga_pixel_fetch on a small 4x2 frame.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    localparam int          H     = 4;
    localparam int          V     = 2;
    localparam int          NPIX  = H * V;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic         clk;
    logic         rst;
    logic         frame_start;
    logic         pix_rd;
    logic [23:0]  pix_data;
    logic         underflow;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [15:0]  underflow_cnt;
    fetch_state_t fsm_state;

    vga_pixel_fetch #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .pix_rd        (pix_rd),
        .pix_data      (pix_data),
        .underflow     (underflow),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
`ifdef VGA_FETCH_STATS_EN
        .underflow_cnt (underflow_cnt),
`endif
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: pixel queue, words fetched since frame start, pending drop
    logic [23:0] fifo_m[$];
    logic [40:0] exp_q[$];
    int          n_words;
    bit          discard_pending;
    logic [23:0] last_pix;
    int          uf_total;
    int          acks;
    bit          prev_ack;
    bit          rd_issued;
    int          pass_cnt;
    int          total_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_model();
        fifo_m.delete();
        n_words         = 0;
        discard_pending = 0;
        last_pix        = '0;
        uf_total        = 0;
        prev_ack        = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst         = 1'b1;
        pix_rd      = 1'b0;
        frame_start = 1'b0;
        mem_ack     = 1'b0;
        rd_issued   = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_pix_data", 32'(pix_data), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, BASE);
`ifdef VGA_FETCH_STATS_EN
        check("rst_underflow_cnt", 32'(underflow_cnt), 32'h0);
`endif
        clear_model();
        rst = 1'b0;
    endtask

    // driver: one cycle of stimulus plus reference-model update
    task automatic step(input int ack_pct, input int rd_pct, input int fs_pct);
        logic uf;
        @(negedge clk);
        if (prev_ack) check("turnaround_idle", 32'(mem_req), 32'h0);
        if (fifo_m.size() == DEPTH) check("no_req_when_full", 32'(mem_req), 32'h0);
        frame_start = ($urandom_range(0, 99) < fs_pct);
        pix_rd      = ($urandom_range(0, 99) < rd_pct);
        mem_ack     = mem_req && !frame_start && ($urandom_range(0, 99) < ack_pct);
        mem_rdata   = $urandom;
        prev_ack    = mem_ack;
        if (frame_start) begin
            if (mem_req) discard_pending = 1;
            fifo_m.delete();
            n_words = 0;
            if (pix_rd) exp_q.push_back({16'(uf_total), 1'b0, last_pix});
        end else begin
            if (pix_rd) begin
                uf = (fifo_m.size() == 0);
                if (uf) begin
                    last_pix = '0;
                    if (uf_total < 65535) uf_total++;
                end else begin
                    last_pix = fifo_m.pop_front();
                end
                exp_q.push_back({16'(uf_total), uf, last_pix});
            end
            if (mem_ack) begin
                if (discard_pending) begin
                    discard_pending = 0;
                end else begin
                    check("mem_addr", mem_addr, BASE + 32'((n_words % NPIX) * 4));
                    fifo_m.push_back(mem_rdata[23:0]);
                    n_words++;
                    acks++;
                end
            end
        end
        rd_issued = pix_rd;
    endtask

    // monitor: compare the registered pixel output one cycle after each pop request
    initial begin
        bit          chk;
        logic [40:0] e;
        forever begin
            @(posedge clk);
            chk = rd_issued;
            @(negedge clk);
            if (chk) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_empty", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(pix_data), 32'(e[23:0]));
                    check("underflow", 32'(underflow), 32'(e[24]));
`ifdef VGA_FETCH_STATS_EN
                    check("underflow_cnt", 32'(underflow_cnt), 32'(e[40:25]));
`endif
                end
            end else begin
                check("underflow_idle", 32'(underflow), 32'h0);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        rd_issued   = 1'b0;
        pass_cnt    = 0;
        total_cnt   = 0;
        acks        = 0;
        clear_model();

        do_reset(3);
        // fill from reset: eight back-to-back words, then the request line goes quiet
        step(100, 0, 0);
        check("first_req", 32'(mem_req), 32'h1);
        repeat (29) step(100, 0, 0);
        check("fill_words", 32'(acks), 32'd8);
        check("full_no_req", 32'(mem_req), 32'h0);

        // three pops, then exactly three refills
        repeat (3) step(0, 100, 0);
        repeat (12) step(100, 0, 0);
        check("refill_words", 32'(acks), 32'd11);

        // drain with acks withheld to force underflow
        repeat (12) step(0, 100, 0);

        repeat (3000) step(50, 50, 2);
        repeat (300) step(100, 100, 0);
        repeat (1500) step(20, 40, 8);

        // reset with a request outstanding
        repeat (3) step(0, 0, 0);
        do_reset(2);
        step(100, 0, 0);
        check("first_req_after_rst", 32'(mem_req), 32'h1);
        repeat (2000) step(60, 60, 1);

        @(negedge clk);
        pix_rd      = 1'b0;
        frame_start = 1'b0;
        mem_ack     = 1'b0;
        rd_issued   = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
